// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiply/divide unit: issues ops to an external pipelined
// multiplier and iterative divider, owns HI/LO, and handles busy/flush for the pipeline.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic        issue_ready,
    input  logic        flush,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic        mul_signed,
    input  logic [63:0] mul_res,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    input  logic        div_complete,
    output logic        div_cancel
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic               hi_we;
    logic               lo_we;
    logic [31:0]        hi_d;
    logic [31:0]        lo_d;

    logic [31:0]        x_q;
    logic [31:0]        y_q;
    logic               mul_signed_q;
    logic               div_signed_q;

    logic               mul_acc;
    logic               div_acc;

    assign mul_acc = issue_valid && issue_ready &&
                     ((issue_op == OP_MULT) || (issue_op == OP_MULTU));
    assign div_acc = issue_valid && issue_ready &&
                     ((issue_op == OP_DIV) || (issue_op == OP_DIVU));

    // Operands go straight through in the accept cycle, then come from the holding regs.
    assign mul_x      = mul_acc ? issue_a : x_q;
    assign mul_y      = mul_acc ? issue_b : y_q;
    assign mul_signed = mul_acc ? (issue_op == OP_MULT) : mul_signed_q;
    assign div_x      = div_acc ? issue_a : x_q;
    assign div_y      = div_acc ? issue_b : y_q;
    assign div_signed = div_acc ? (issue_op == OP_DIV) : div_signed_q;

    assign busy_o = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, handshake and HI/LO write control
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        issue_ready = 1'b0;
        done_o      = 1'b0;
        div_start   = 1'b0;
        div_cancel  = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        hi_d        = hi_o;
        lo_d        = lo_o;

        case (state)
            S_IDLE: begin
                issue_ready = !flush;
                if (issue_valid && !flush) begin
                    case (issue_op)
                        OP_MULT, OP_MULTU: begin
                            state_nxt = S_MUL;
                            cnt_nxt   = CNT_W'(1);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nxt = S_DIV;
                            div_start = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_we = 1'b1;
                            hi_d  = issue_a;
                        end
                        OP_MTLO: begin
                            lo_we = 1'b1;
                            lo_d  = issue_a;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(MUL_LAT)) begin
                    hi_we     = 1'b1;
                    lo_we     = 1'b1;
                    hi_d      = mul_res[63:32];
                    lo_d      = mul_res[31:0];
                    done_o    = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DIV: begin
                if (flush) begin
                    div_cancel = 1'b1;
                    state_nxt  = S_IDLE;
                end else if (div_complete) begin
                    hi_we     = 1'b1;
                    lo_we     = 1'b1;
                    hi_d      = div_r;
                    lo_d      = div_s;
                    done_o    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Architectural HI/LO and operand holding registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_o         <= '0;
            lo_o         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
        end else begin
            if (hi_we) hi_o <= hi_d;
            if (lo_we) lo_o <= lo_d;
            if (mul_acc || div_acc) begin
                x_q <= issue_a;
                y_q <= issue_b;
            end
            if (mul_acc) mul_signed_q <= (issue_op == OP_MULT);
            if (div_acc) div_signed_q <= (issue_op == OP_DIV);
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with a pipelined multiplier model and a
// fixed-latency divider model; HI/LO expectations come from plain arithmetic.
module tb_muldiv_ctrl;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        resetn;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        issue_ready;
    logic        flush;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic        mul_signed;
    logic [63:0] mul_res;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic [31:0] div_s;
    logic [31:0] div_r;
    logic        div_complete;
    logic        div_cancel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .issue_ready  (issue_ready),
        .flush        (flush),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .mul_x        (mul_x),
        .mul_y        (mul_y),
        .mul_signed   (mul_signed),
        .mul_res      (mul_res),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_x        (div_x),
        .div_y        (div_y),
        .div_s        (div_s),
        .div_r        (div_r),
        .div_complete (div_complete),
        .div_cancel   (div_cancel)
    );

    function automatic logic [63:0] mul_ref(logic sgn, logic [31:0] x, logic [31:0] y);
        int     sx;
        int     sy;
        longint p;
        sx = x;
        sy = y;
        if (sgn) p = longint'(sx) * longint'(sy);
        else     p = longint'({32'b0, x}) * longint'({32'b0, y});
        return 64'(p);
    endfunction

    // Returns {remainder, quotient}; zero divisor and signed overflow given fixed values.
    function automatic logic [63:0] div_ref(logic sgn, logic [31:0] x, logic [31:0] y);
        int sx;
        int sy;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = x;
        sy = y;
        if (sgn) return {32'(sx % sy), 32'(sx / sy)};
        return {x % y, x / y};
    endfunction

    // Multiplier model: product of operands seen at an edge appears MUL_LAT cycles later.
    logic [63:0] mul_pipe [MUL_LAT];
    assign mul_res = mul_pipe[MUL_LAT-1];
    always @(posedge clk) begin
        mul_pipe[0] <= mul_ref(mul_signed, mul_x, mul_y);
        for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    // Divider model with a manual completion override for coincidence tests.
    bit          div_model_en = 1'b1;
    logic        man_complete;
    logic        model_complete;
    int          dcnt;
    assign div_complete = model_complete | man_complete;
    always @(posedge clk) begin
        model_complete <= 1'b0;
        if (!resetn || div_cancel) begin
            dcnt <= 0;
        end else if (div_start && div_model_en) begin
            dcnt <= int'(DIV_LAT);
            {div_r, div_s} <= div_ref(div_signed, div_x, div_y);
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) model_complete <= 1'b1;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Waits (bounded) for done_o, then advances past the write edge.
    task automatic wait_done(string tag);
        for (int c = 0; c < 200; c++) begin
            #1;
            if (done_o === 1'b1) begin
                step();
                return;
            end
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: got no done_o expected done_o within 200 cycles", tag);
    endtask

    // Issues one op, optionally flushes it flush_at cycles after accept, checks HI/LO after.
    task automatic apply(string tag, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         int flush_at, logic [31:0] ehi, logic [31:0] elo);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        #1;
        chk({tag, "_ready"}, 64'(issue_ready), 64'd1);
        step();
        issue_valid = 1'b0;
        if (op <= 3'd3) begin
            if (flush_at > 0) begin
                for (int c = 1; c < flush_at; c++) step();
                flush = 1'b1;
                #1;
                chk({tag, "_flush_done"}, 64'(done_o), 64'd0);
                if (op >= 3'd2) chk({tag, "_cancel"}, 64'(div_cancel), 64'd1);
                step();
                flush = 1'b0;
            end else begin
                wait_done(tag);
            end
        end
        #1;
        chk({tag, "_hi"}, 64'(hi_o), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo_o), 64'(elo));
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          flush_at;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'd4, 32'h1234_5678, 32'd0,          0, 32'h1234_5678, 32'h0000_0000};
        tbl[1]  = '{3'd5, 32'h9ABC_DEF0, 32'd0,          0, 32'h1234_5678, 32'h9ABC_DEF0};
        tbl[2]  = '{3'd2, 32'd100,       32'd7,          3, 32'h1234_5678, 32'h9ABC_DEF0};
        tbl[3]  = '{3'd0, 32'hFFFF_FFFF, 32'd2,    MUL_LAT, 32'h1234_5678, 32'h9ABC_DEF0};
        tbl[4]  = '{3'd0, 32'hFFFF_FFFF, 32'd2,          0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[5]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          0, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[6]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,          0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[7]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,          0, 32'h0000_0001, 32'h7FFF_FFFC};
        tbl[8]  = '{3'd6, 32'hDEAD_BEEF, 32'd1,          0, 32'h0000_0001, 32'h7FFF_FFFC};
        tbl[9]  = '{3'd0, 32'h8000_0000, 32'h8000_0000,  0, 32'h4000_0000, 32'h0000_0000};
        tbl[10] = '{3'd0, 32'd7,         32'hFFFF_FFFD,  0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[11] = '{3'd7, 32'hCAFE_F00D, 32'd3,          0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

        resetn       = 1'b0;
        issue_valid  = 1'b0;
        issue_op     = 3'd0;
        issue_a      = '0;
        issue_b      = '0;
        flush        = 1'b0;
        man_complete = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        #1;
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_ready", 64'(issue_ready), 64'd1);
        chk("rst_divstart", 64'({div_start, div_cancel}), 64'd0);
        chk("rst_operands", {mul_x, div_y}, 64'd0);
        chk("rst_signed", 64'({mul_signed, div_signed}), 64'd0);

        for (int i = 0; i < 12; i++)
            apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].flush_at, tbl[i].hi, tbl[i].lo);

        // MULTU timing: busy exactly T+1..T+2, done in T+2, result visible T+3
        step();
        issue_valid = 1'b1; issue_op = 3'd1; issue_a = 32'hFFFF_FFFF; issue_b = 32'd2;
        #1;
        chk("mu_T_busy", 64'(busy_o), 64'd0);
        chk("mu_T_ops", {mul_x, mul_y}, {32'hFFFF_FFFF, 32'd2});
        chk("mu_T_sgn", 64'(mul_signed), 64'd0);
        step();
        issue_valid = 1'b0; issue_a = 32'd0; issue_b = 32'd0;
        #1;
        chk("mu_T1_busy_done", 64'({busy_o, done_o}), 64'b10);
        chk("mu_T1_ops_held", {mul_x, mul_y}, {32'hFFFF_FFFF, 32'd2});
        step();
        #1;
        chk("mu_T2_busy_done", 64'({busy_o, done_o}), 64'b11);
        step();
        #1;
        chk("mu_T3_busy_ready", 64'({busy_o, issue_ready}), 64'b01);
        chk("mu_T3_hilo", {hi_o, lo_o}, {32'h0000_0001, 32'hFFFF_FFFE});

        // DIV: single div_start pulse, operands and sign held
        issue_valid = 1'b1; issue_op = 3'd2; issue_a = 32'hFFFF_FFF9; issue_b = 32'd2;
        #1;
        chk("dv_T_start", 64'(div_start), 64'd1);
        chk("dv_T_ops", {div_x, div_y}, {32'hFFFF_FFF9, 32'd2});
        step();
        issue_valid = 1'b0; issue_a = 32'd5; issue_b = 32'd9;
        #1;
        chk("dv_T1_start", 64'(div_start), 64'd0);
        chk("dv_T1_ops_held", {div_x, div_y}, {32'hFFFF_FFF9, 32'd2});
        chk("dv_T1_sgn_busy", 64'({div_signed, busy_o}), 64'b11);
        step();
        wait_done("dv");
        #1;
        chk("dv_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Back-to-back MTHI / MTLO
        issue_valid = 1'b1; issue_op = 3'd4; issue_a = 32'h1234_5678;
        #1;
        chk("mt_hi_ready", 64'(issue_ready), 64'd1);
        step();
        issue_op = 3'd5; issue_a = 32'h9ABC_DEF0;
        #1;
        chk("mt_lo_ready", 64'(issue_ready), 64'd1);
        chk("mt_hi_val", 64'(hi_o), 64'h1234_5678);
        step();
        issue_valid = 1'b0;
        #1;
        chk("mt_hilo", {hi_o, lo_o}, {32'h1234_5678, 32'h9ABC_DEF0});

        // Flush coincident with div_complete: cancel wins, no done, HI/LO kept
        div_model_en = 1'b0;
        issue_valid = 1'b1; issue_op = 3'd3; issue_a = 32'd100; issue_b = 32'd7;
        step();
        issue_valid = 1'b0;
        step();
        step();
        flush = 1'b1; man_complete = 1'b1;
        #1;
        chk("fc_done", 64'(done_o), 64'd0);
        chk("fc_cancel", 64'(div_cancel), 64'd1);
        step();
        flush = 1'b0; man_complete = 1'b0;
        #1;
        chk("fc_cancel_pulse", 64'({div_cancel, busy_o}), 64'd0);
        chk("fc_hilo", {hi_o, lo_o}, {32'h1234_5678, 32'h9ABC_DEF0});
        // Stray div_complete in IDLE is ignored
        man_complete = 1'b1;
        #1;
        chk("stray_done", 64'(done_o), 64'd0);
        step();
        man_complete = 1'b0;
        #1;
        chk("stray_hilo", {hi_o, lo_o}, {32'h1234_5678, 32'h9ABC_DEF0});
        div_model_en = 1'b1;
        // Flush in IDLE blocks acceptance
        flush = 1'b1; issue_valid = 1'b1; issue_op = 3'd4; issue_a = 32'hDEAD_0000;
        #1;
        chk("fi_ready", 64'(issue_ready), 64'd0);
        step();
        flush = 1'b0; issue_valid = 1'b0;
        #1;
        chk("fi_hi", 64'(hi_o), 64'h1234_5678);

        // Randomized ops against the arithmetic reference
        ref_hi = 32'h1234_5678;
        ref_lo = 32'h9ABC_DEF0;
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] r;
            int          fa;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 16));
            fa = 0;
            if (op <= 3'd3 && $urandom_range(0, 7) == 0)
                fa = (op <= 3'd1) ? $urandom_range(1, MUL_LAT) : $urandom_range(1, 8);
            if (fa == 0) begin
                case (op)
                    3'd0, 3'd1: begin
                        r = mul_ref(op == 3'd0, a, b);
                        ref_hi = r[63:32]; ref_lo = r[31:0];
                    end
                    3'd2, 3'd3: begin
                        r = div_ref(op == 3'd2, a, b);
                        ref_hi = r[63:32]; ref_lo = r[31:0];
                    end
                    3'd4: ref_hi = a;
                    3'd5: ref_lo = a;
                    default: ;
                endcase
            end
            apply($sformatf("rnd%0d_op%0d", i, op), op, a, b, fa, ref_hi, ref_lo);
        end

        // Reset mid-MUL: back to IDLE with cleared HI/LO, late product ignored
        issue_valid = 1'b1; issue_op = 3'd0; issue_a = 32'd3; issue_b = 32'd5;
        step();
        issue_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rm_busy_before", 64'(busy_o), 64'd1);
        step();
        resetn = 1'b1;
        #1;
        chk("rm_state", 64'({busy_o, issue_ready, done_o}), 64'b010);
        chk("rm_hilo", {hi_o, lo_o}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            chk($sformatf("rm_late%0d", c), {31'd0, done_o, hi_o ^ lo_o}, 64'd0);
        end
        chk("rm_hilo_end", {hi_o, lo_o}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
